// File: rtl/ps2_pkg.sv
//==============================================================================
// Module      : ps2_pkg
// Description : Shared types, prefix constants and timeout helper for the
//               PS/2 keyboard receiver.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ps2_pkg;

  // Frame-level receiver states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Scancode prefixes announcing a key release and an extended key
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;

  // Number of system clock cycles allowed between falling edges in a frame
  function automatic int ps2_timeout_cyc(input int clk_hz, input int timeout_us);
    return (clk_hz / 1_000_000) * timeout_us;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_filter.sv
//==============================================================================
// Module      : ps2_line_filter
// Description : Two-flop synchronizer, run-length glitch filter and falling
//               edge strobe for the raw PS/2 clock pin.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic fall_o
);

  localparam int CNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             level_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Bring the asynchronous pin into the clk domain; idle bus level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the filtered level; flip on the FILTER_LEN-th
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Delayed copy of the filtered level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_dly_q <= 1'b1;
    end else begin
      level_dly_q <= level_q;
    end
  end

  // Both operands are flops, so the strobe is clean and exactly one cycle wide
  assign fall_o = level_dly_q & ~level_q;

endmodule

`default_nettype wire

// File: rtl/ps2_rx.sv
//==============================================================================
// Module      : ps2_rx
// Description : PS/2 keyboard frame receiver with parity/stop/timeout
//               checking and a single-entry valid/ready output register.
//               Optional make/break prefix decoding is enabled by defining
//               PS2_RX_BREAK_DECODE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_break,
  output logic       code_ext,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TMO_CYC = ps2_timeout_cyc(CLK_HZ, TIMEOUT_US);
  localparam int TMO_W   = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  // Input conditioning
  logic w_fall;
  logic dsync1_q;
  logic dsync2_q;

  // Frame FSM
  ps2_state_e       state_q;
  logic [2:0]       bitcnt_q;
  logic [7:0]       shift_q;
  logic             par_q;
  logic [TMO_W-1:0] tmo_q;
  logic             frame_err_q;

  logic w_tmo_hit;
  logic w_stop_fall;
  logic w_par_ok;
  logic w_good;
  logic w_err;

  // Delivery path
  logic w_deliver;
  logic w_del_brk;
  logic w_del_ext;

  logic [7:0] code_q;
  logic       code_break_q;
  logic       code_ext_q;
  logic       code_valid_q;
  logic       overrun_q;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (ps2_clk),
    .fall_o (w_fall)
  );

  // Data pin only needs synchronizing; it is sampled on the filtered clock strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsync1_q <= 1'b1;
      dsync2_q <= 1'b1;
    end else begin
      dsync1_q <= ps2_data;
      dsync2_q <= dsync1_q;
    end
  end

  // A strobe arriving on the terminal count cycle counts as progress, not a timeout
  assign w_tmo_hit   = (state_q != ST_IDLE) && !w_fall && (tmo_q == TMO_LAST);
  assign w_stop_fall = (state_q == ST_STOP) && w_fall;
  assign w_par_ok    = ^{shift_q, par_q};
  assign w_good      = w_stop_fall && dsync2_q && w_par_ok;
  assign w_err       = w_tmo_hit || (w_stop_fall && !w_good);

  // Frame FSM: start bit, 8 data bits LSB first, odd parity, stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= w_err;
      if (w_tmo_hit) begin
        state_q <= ST_IDLE;
        tmo_q   <= '0;
      end else begin
        if ((state_q == ST_IDLE) || w_fall) begin
          tmo_q <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        case (state_q)
          ST_IDLE: begin
            // A high sample here is line noise or a stray edge, not a start bit
            if (w_fall && !dsync2_q) begin
              state_q  <= ST_DATA;
              bitcnt_q <= '0;
            end
          end
          ST_DATA: begin
            if (w_fall) begin
              shift_q  <= {dsync2_q, shift_q[7:1]};
              bitcnt_q <= bitcnt_q + 1'b1;
              if (bitcnt_q == 3'd7) begin
                state_q <= ST_PARITY;
              end
            end
          end
          ST_PARITY: begin
            if (w_fall) begin
              par_q   <= dsync2_q;
              state_q <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (w_fall) begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef PS2_RX_BREAK_DECODE_EN
  logic brk_pend_q;
  logic ext_pend_q;

  // Prefix bytes are absorbed into pending flags that tag the next real scancode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
    end else if (w_err) begin
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
    end else if (w_good) begin
      if (shift_q == PS2_BREAK_PREFIX) begin
        brk_pend_q <= 1'b1;
      end else if (shift_q == PS2_EXT_PREFIX) begin
        ext_pend_q <= 1'b1;
      end else begin
        brk_pend_q <= 1'b0;
        ext_pend_q <= 1'b0;
      end
    end
  end

  assign w_deliver = w_good && (shift_q != PS2_BREAK_PREFIX) && (shift_q != PS2_EXT_PREFIX);
  assign w_del_brk = brk_pend_q;
  assign w_del_ext = ext_pend_q;
`else
  assign w_deliver = w_good;
  assign w_del_brk = 1'b0;
  assign w_del_ext = 1'b0;
`endif

  // Single-entry output register; a byte arriving while one is still held is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q       <= '0;
      code_break_q <= 1'b0;
      code_ext_q   <= 1'b0;
      code_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (w_deliver) begin
        if (!code_valid_q || code_ready) begin
          code_q       <= shift_q;
          code_break_q <= w_del_brk;
          code_ext_q   <= w_del_ext;
          code_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (code_valid_q && code_ready) begin
        code_valid_q <= 1'b0;
      end
    end
  end

  assign code       = code_q;
  assign code_break = code_break_q;
  assign code_ext   = code_ext_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

`default_nettype wire
